// File: rtl/quad_encoder_gen.sv
// quad_encoder_gen: quadrature encoder waveform generator.
// Produces A/B quadrature channels, an index mark, a one-clock edge strobe and
// a signed edge count from a commanded step period (in prescaled ticks) and a
// direction. Period and direction are shadowed so a step in flight always
// completes with the timing it started with.
module quad_encoder_gen #(
   parameter int DATA_WIDTH = 16,
   parameter int PRESCALE   = 64,
   parameter int CPR        = 400
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  direction,
   input  logic [DATA_WIDTH-1:0] step_period,
   output logic                  encoder_a,
   output logic                  encoder_b,
   output logic                  index,
   output logic                  step_pulse,
   output logic [DATA_WIDTH-1:0] position
);

   localparam int TICK_W = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
   localparam int REV_W  = $clog2(CPR);

   localparam logic [TICK_W-1:0]     TICK_LAST = TICK_W'(PRESCALE);
   localparam logic [REV_W-1:0]      REV_LAST  = REV_W'(CPR - 1);
   localparam logic [REV_W-1:0]      REV_ONE   = REV_W'(1);
   localparam logic [TICK_W-1:0]     TICK_ONE  = TICK_W'(1);
   localparam logic [DATA_WIDTH-1:0] DATA_ONE  = DATA_WIDTH'(1);

   // Phase encoding is {A,B}; the forward Gray walk is 00->01->11->10.
   typedef enum logic [1:0] {
      PH_00 = 2'b00,
      PH_01 = 2'b01,
      PH_11 = 2'b11,
      PH_10 = 2'b10
   } phase_t;

   logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
   logic [DATA_WIDTH-1:0] step_cnt_q, step_cnt_d;
   logic [DATA_WIDTH-1:0] period_q, period_d;
   logic                  dir_q, dir_d;
   phase_t                phase_q, phase_d;
   logic [DATA_WIDTH-1:0] position_q, position_d;
   logic [REV_W-1:0]      rev_q, rev_d;
   logic                  step_pulse_q, step_pulse_d;

   logic   tick;
   logic   step_edge;
   phase_t phase_fwd;
   phase_t phase_rev;

   // Neighbouring phases in each direction; exactly one channel differs.
   always_comb begin
      phase_fwd = PH_00;
      phase_rev = PH_00;
      case (phase_q)
         PH_00: begin
            phase_fwd = PH_01;
            phase_rev = PH_10;
         end
         PH_01: begin
            phase_fwd = PH_11;
            phase_rev = PH_00;
         end
         PH_11: begin
            phase_fwd = PH_10;
            phase_rev = PH_01;
         end
         PH_10: begin
            phase_fwd = PH_00;
            phase_rev = PH_11;
         end
         default: begin
            phase_fwd = PH_00;
            phase_rev = PH_00;
         end
      endcase
   end

   // Tick prescaler, step timing, shadow latching and edge bookkeeping.
   always_comb begin
      tick_cnt_d   = tick_cnt_q;
      step_cnt_d   = step_cnt_q;
      period_d     = period_q;
      dir_d        = dir_q;
      phase_d      = phase_q;
      position_d   = position_q;
      rev_d        = rev_q;
      step_pulse_d = 1'b0;
      tick         = 1'b0;
      step_edge    = 1'b0;

      if (!enable) begin
         tick_cnt_d = '0;
         step_cnt_d = '0;
      end else begin
         if (tick_cnt_q == TICK_LAST) begin
            tick       = 1'b1;
            tick_cnt_d = '0;
         end else begin
            tick_cnt_d = tick_cnt_q + TICK_ONE;
         end

         if (tick) begin
            if (period_q == '0) begin
               period_d   = step_period;
               dir_d      = direction;
               step_cnt_d = '0;
            end else if (step_cnt_q == (period_q - DATA_ONE)) begin
               step_edge  = 1'b1;
            end else begin
               step_cnt_d = step_cnt_q + DATA_ONE;
            end
         end
      end

      if (step_edge) begin
         step_cnt_d   = '0;
         step_pulse_d = 1'b1;
         period_d     = step_period;
         dir_d        = direction;
         if (dir_q) begin
            phase_d    = phase_rev;
            position_d = position_q - DATA_ONE;
            rev_d      = (rev_q == '0) ? REV_LAST : (rev_q - REV_ONE);
         end else begin
            phase_d    = phase_fwd;
            position_d = position_q + DATA_ONE;
            rev_d      = (rev_q == REV_LAST) ? '0 : (rev_q + REV_ONE);
         end
      end
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         tick_cnt_q   <= '0;
         step_cnt_q   <= '0;
         period_q     <= '0;
         dir_q        <= 1'b0;
         phase_q      <= PH_00;
         position_q   <= '0;
         rev_q        <= '0;
         step_pulse_q <= 1'b0;
      end else begin
         tick_cnt_q   <= tick_cnt_d;
         step_cnt_q   <= step_cnt_d;
         period_q     <= period_d;
         dir_q        <= dir_d;
         phase_q      <= phase_d;
         position_q   <= position_d;
         rev_q        <= rev_d;
         step_pulse_q <= step_pulse_d;
      end
   end

   assign encoder_a  = phase_q[1];
   assign encoder_b  = phase_q[0];
   assign index      = (rev_q == '0);
   assign step_pulse = step_pulse_q;
   assign position   = position_q;

endmodule

// File: tb/tb_quad_encoder_gen.sv
// tb_quad_encoder_gen: directed and randomized checks of quad_encoder_gen
// against a behavioural reference model feeding an edge scoreboard.
module tb_quad_encoder_gen;

   localparam int W    = 8;
   localparam int PS   = 4;
   localparam int CPR  = 10;
   localparam int TPER = PS + 1;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         enable = 1'b0;
   logic         direction = 1'b0;
   logic [W-1:0] step_period = '0;
   logic         encoder_a;
   logic         encoder_b;
   logic         index;
   logic         step_pulse;
   logic [W-1:0] position;

   quad_encoder_gen #(
      .DATA_WIDTH(W),
      .PRESCALE(PS),
      .CPR(CPR)
   ) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .direction(direction),
      .step_period(step_period),
      .encoder_a(encoder_a),
      .encoder_b(encoder_b),
      .index(index),
      .step_pulse(step_pulse),
      .position(position)
   );

   always #5 clk = ~clk;

   typedef struct {
      longint       cyc;
      logic [1:0]   ab;
      logic [W-1:0] pos;
      logic         idx;
   } edge_rec_t;

   edge_rec_t exp_q[$];
   edge_rec_t pulse_log[$];

   int     total = 0;
   int     bad = 0;
   longint cyc = 0;

   int           m_run = 0;
   int           m_since = 0;
   logic [W-1:0] m_lat_p = '0;
   logic         m_lat_d = 1'b0;
   int           m_ph = 0;
   logic [W-1:0] m_pos = '0;
   int           m_rev = 0;
   logic         m_pulse = 1'b0;

   // Position on the quadrature cycle (0..3) mapped to the {A,B} levels.
   function automatic logic [1:0] gray(input int ph);
      case (ph)
         0:       return 2'b00;
         1:       return 2'b01;
         2:       return 2'b11;
         default: return 2'b10;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("[TB] FAIL %s: got=%0h want=%0h at cycle %0d", name, got, want, cyc);
      end
   endtask

   task automatic applyStimulus(input logic rst_n, input logic en, input logic dir,
                                input logic [W-1:0] per, input int ncycles);
      reset       = rst_n;
      enable      = en;
      direction   = dir;
      step_period = per;
      for (int i = 0; i < ncycles; i++) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic waitPulses(input int n, input int budget);
      int waited;
      waited = 0;
      while (pulse_log.size() < n && waited < budget) begin
         @(negedge clk);
         #1;
         waited++;
      end
      if (pulse_log.size() < n) checkOutput("pulse_timeout", pulse_log.size(), n);
   endtask

   // Reference model: ticks every TPER enabled clocks; an edge once the
   // latched number of ticks has elapsed since the previous edge.
   initial begin
      edge_rec_t e;
      forever begin
         @(posedge clk);
         cyc++;
         m_pulse = 1'b0;
         if (!reset) begin
            m_run   = 0;
            m_since = 0;
            m_lat_p = '0;
            m_lat_d = 1'b0;
            m_ph    = 0;
            m_pos   = '0;
            m_rev   = 0;
         end else if (!enable) begin
            m_run   = 0;
            m_since = 0;
         end else begin
            if ((m_run % TPER) == PS) begin
               if (m_lat_p == 0) begin
                  m_lat_p = step_period;
                  m_lat_d = direction;
               end else begin
                  m_since++;
                  if (m_since == int'(m_lat_p)) begin
                     m_since = 0;
                     m_ph    = m_lat_d ? (m_ph + 3) % 4 : (m_ph + 1) % 4;
                     m_pos   = m_lat_d ? m_pos - W'(1) : m_pos + W'(1);
                     m_rev   = m_lat_d ? (m_rev + CPR - 1) % CPR : (m_rev + 1) % CPR;
                     m_lat_p = step_period;
                     m_lat_d = direction;
                     m_pulse = 1'b1;
                     e.cyc = cyc;
                     e.ab  = gray(m_ph);
                     e.pos = m_pos;
                     e.idx = (m_rev == 0);
                     exp_q.push_back(e);
                  end
               end
            end
            m_run++;
         end
      end
   end

   // Monitor: pops an expected edge for every strobe and checks steady state.
   initial begin
      edge_rec_t e;
      edge_rec_t got;
      forever begin
         @(negedge clk);
         if (cyc > 0) begin
            if (step_pulse === 1'b1) begin
               got.cyc = cyc;
               got.ab  = {encoder_a, encoder_b};
               got.pos = position;
               got.idx = index;
               pulse_log.push_back(got);
               if (exp_q.size() == 0) begin
                  checkOutput("spurious_edge", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  checkOutput("edge_cycle", 32'(cyc), 32'(e.cyc));
                  checkOutput("edge_fields", {21'd0, got.ab, got.pos, got.idx},
                              {21'd0, e.ab, e.pos, e.idx});
               end
            end
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
               e = exp_q.pop_front();
               checkOutput("missed_edge", 32'(cyc), 32'(e.cyc));
            end
            checkOutput("state", {20'd0, encoder_a, encoder_b, index, step_pulse, position},
                        {20'd0, gray(m_ph), (m_rev == 0), m_pulse, m_pos});
         end
      end
   end

   initial begin
      longint c0;
      int     n0;

      // Reset state, then forward at period 3 straight out of reset.
      @(negedge clk);
      #1;
      applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 3);
      checkOutput("reset_state", {encoder_a, encoder_b, index, step_pulse, position},
                  {1'b0, 1'b0, 1'b1, 1'b0, 8'd0});
      pulse_log.delete();
      c0 = cyc;
      applyStimulus(1'b1, 1'b1, 1'b0, 8'd3, 0);
      waitPulses(6, 400);
      if (pulse_log.size() >= 6) begin
         checkOutput("fwd_first_edge", 32'(pulse_log[0].cyc - c0), 20);
         checkOutput("fwd_seq", {pulse_log[0].ab, pulse_log[1].ab, pulse_log[2].ab, pulse_log[3].ab},
                     8'b01_11_10_00);
         checkOutput("fwd_pos4", pulse_log[3].pos, 8'd4);
         checkOutput("fwd_spacing", 32'(pulse_log[2].cyc - pulse_log[1].cyc), 3 * TPER);
         checkOutput("fwd_a_rise_rise", 32'(pulse_log[5].cyc - pulse_log[1].cyc), 4 * 3 * TPER);
      end

      // Reverse at period 2: mirrored sequence, negative count, index wrap.
      applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 2);
      pulse_log.delete();
      applyStimulus(1'b1, 1'b1, 1'b1, 8'd2, 0);
      waitPulses(CPR, 600);
      if (pulse_log.size() >= CPR) begin
         checkOutput("rev_seq", {pulse_log[0].ab, pulse_log[1].ab, pulse_log[2].ab, pulse_log[3].ab},
                     8'b10_11_01_00);
         checkOutput("rev_pos4", pulse_log[3].pos, 8'hFC);
         checkOutput("rev_index_after1", pulse_log[0].idx, 1'b0);
         checkOutput("rev_index_afterCPR", pulse_log[CPR-1].idx, 1'b1);
      end

      // Period shortened mid-step: current step keeps the old period.
      applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 2);
      pulse_log.delete();
      applyStimulus(1'b1, 1'b1, 1'b0, 8'd4, 0);
      waitPulses(1, 200);
      applyStimulus(1'b1, 1'b1, 1'b0, 8'd4, 7);
      step_period = 8'd1;
      waitPulses(3, 200);
      if (pulse_log.size() >= 3) begin
         checkOutput("chg_old_period", 32'(pulse_log[1].cyc - pulse_log[0].cyc), 4 * TPER);
         checkOutput("chg_new_period", 32'(pulse_log[2].cyc - pulse_log[1].cyc), 1 * TPER);
      end

      // Direction flipped before the edge into 01: the next edge walks back to 00.
      applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 2);
      pulse_log.delete();
      applyStimulus(1'b1, 1'b1, 1'b0, 8'd3, 10);
      direction = 1'b1;
      waitPulses(3, 200);
      if (pulse_log.size() >= 3) begin
         checkOutput("flip_seq", {pulse_log[0].ab, pulse_log[1].ab, pulse_log[2].ab}, 6'b01_00_10);
         checkOutput("flip_pos", {pulse_log[0].pos, pulse_log[1].pos, pulse_log[2].pos},
                     {8'd1, 8'd0, 8'hFF});
      end

      // Enable low freezes everything; re-enable restarts the step from zero.
      applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 2);
      pulse_log.delete();
      applyStimulus(1'b1, 1'b1, 1'b0, 8'd2, 0);
      waitPulses(3, 200);
      applyStimulus(1'b1, 1'b1, 1'b0, 8'd2, 4);
      n0 = pulse_log.size();
      applyStimulus(1'b1, 1'b0, 1'b0, 8'd2, 300);
      checkOutput("frozen_no_pulse", pulse_log.size(), n0);
      checkOutput("frozen_ab", {encoder_a, encoder_b, position}, {2'b10, 8'd3});
      c0 = cyc;
      applyStimulus(1'b1, 1'b1, 1'b0, 8'd2, 0);
      waitPulses(n0 + 1, 100);
      if (pulse_log.size() >= n0 + 1)
         checkOutput("reenable_first_edge", 32'(pulse_log[n0].cyc - c0), 2 * TPER);

      // Zero period stops the generator; a nonzero period starts it after latching.
      applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 2);
      pulse_log.delete();
      applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 200);
      checkOutput("zero_period_no_edge", pulse_log.size(), 0);
      c0 = cyc;
      step_period = 8'd5;
      waitPulses(2, 200);
      if (pulse_log.size() >= 2) begin
         checkOutput("start_latency_window",
                     32'((pulse_log[0].cyc - c0 >= 26) && (pulse_log[0].cyc - c0 <= 30)), 1);
         checkOutput("start_spacing", 32'(pulse_log[1].cyc - pulse_log[0].cyc), 5 * TPER);
      end

      // Position wrap at +127 -> -128, then reset in mid-step.
      applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 2);
      pulse_log.delete();
      applyStimulus(1'b1, 1'b1, 1'b0, 8'd1, 0);
      waitPulses(128, 1500);
      if (pulse_log.size() >= 128) begin
         checkOutput("wrap_pos_127", pulse_log[126].pos, 8'h7F);
         checkOutput("wrap_pos_m128", pulse_log[127].pos, 8'h80);
         checkOutput("wrap_index", pulse_log[127].idx, 1'b0);
         checkOutput("wrap_index_rev120", pulse_log[119].idx, 1'b1);
      end
      applyStimulus(1'b1, 1'b1, 1'b0, 8'd1, 2);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'd1, 1);
      checkOutput("midrun_reset", {encoder_a, encoder_b, index, step_pulse, position},
                  {1'b0, 1'b0, 1'b1, 1'b0, 8'd0});

      // Randomized segments; the scoreboard checks every cycle.
      for (int s = 0; s < 60; s++) begin
         applyStimulus(($urandom_range(0, 15) != 0), ($urandom_range(0, 7) != 0),
                       1'($urandom_range(0, 1)), W'($urandom_range(0, 4)),
                       $urandom_range(1, 60));
      end
      applyStimulus(1'b1, 1'b1, 1'b0, 8'd1, 20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
